lsu_mem_ctrl: RTL and testbench

Load/store unit for the multicycle core. It sits between the execute stage and the 256-word write_mem_reg data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores.
- Aligns and sign/zero-extends load data.
- Returns a response over a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, FSM states,
// latched request payload and byte-lane mask generation.
package lsu_pkg;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Only the in-range part of the address is kept; range is checked at accept.
  typedef struct packed {
    logic              wen;
    logic [IDX_W+1:0]  addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              sign;
  } req_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'(4'b0001 << addr_lo);
      SZ_H:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: sub-word store merge and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_mask,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_new_word,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [DATA_W-1:0] w_rep;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Right-justified store data is replicated so every lane sees it.
  always_comb begin
    w_rep      = i_wdata;
    o_new_word = i_word;
    case (i_size)
      SZ_B:    w_rep = {4{i_wdata[7:0]}};
      SZ_H:    w_rep = {2{i_wdata[15:0]}};
      default: w_rep = i_wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (i_mask[i]) o_new_word[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

  always_comb begin
    w_byte    = i_word[{i_addr_lo, 3'b000} +: 8];
    w_half    = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_ld_data = i_word;
    case (i_size)
      SZ_B:    o_ld_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = {{16{i_sign & w_half[15]}}, w_half};
      default: o_ld_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between execute and the word-addressed data memory:
// request handshake, error check, read-modify-write, response handshake.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata
);

  state_t            r_state;
  state_t            w_next;
  req_t              r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_accept;
  logic              w_err;
  logic [3:0]        w_mask;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_ld_data;

  assign w_err = (req_size == 2'd3)
               | ((req_size == SZ_H) & req_addr[0])
               | ((req_size == SZ_W) & (|req_addr[1:0]))
               | (|req_addr[ADDR_W-1:IDX_W+2]);

  assign w_mask = lane_mask(r_req.size, r_req.addr[1:0]);

  lsu_align u_align (
    .i_word     (mem_rdata),
    .i_wdata    (r_req.wdata),
    .i_mask     (w_mask),
    .i_size     (r_req.size),
    .i_addr_lo  (r_req.addr[1:0]),
    .i_sign     (r_req.sign),
    .o_new_word (w_merged),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_err)                         w_next = RESP;
          else if (req_wen && req_size == SZ_W) w_next = WR;
          else                               w_next = RD;
        end
      end
      RD:      w_next = r_req.wen ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_next;
      r_req_ready  <= (w_next == IDLE);
      r_mem_ren    <= (w_next == RD);
      r_mem_wen    <= (w_next == WR);
      r_resp_valid <= (w_next == RESP);
      if (w_accept) begin
        r_req        <= '{wen: req_wen, addr: req_addr[IDX_W+1:0], wdata: req_wdata,
                          size: req_size, sign: req_sign};
        r_resp_err   <= w_err;
        r_resp_rdata <= '0;
        r_mem_wdata  <= req_wdata;
      end
      if (r_state == RD) begin
        if (r_req.wen) r_mem_wdata  <= w_merged;
        else           r_resp_rdata <= w_ld_data;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_ren    = r_mem_ren;
  assign mem_wen    = r_mem_wen;
  assign mem_wdata  = r_mem_wdata;
  assign mem_raddr  = ADDR_W'(r_req.addr[IDX_W+1:2]);
  assign mem_waddr  = ADDR_W'(r_req.addr[IDX_W+1:2]);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 256-word behavioural memory
// (index 0 reads 0, writes to it are dropped).
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_rdata, mem_wdata;
  logic        mem_ren, mem_wen;

  int n_checks = 0;
  int n_err    = 0;
  int wen_total = 0;
  int collisions = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  assign mem_rdata = (mem_raddr[7:0] == 8'd0) ? 32'd0 : mem[mem_raddr[7:0]];

  always @(posedge clk) begin
    if (mem_wen) begin
      wen_total <= wen_total + 1;
      if (mem_waddr[7:0] != 8'd0) mem[mem_waddr[7:0]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (mem_ren && mem_wen) collisions <= collisions + 1;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ren;
    int          exp_wen;
    logic [31:0] exp_wdata;
    logic [31:0] exp_idx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the unit idle.
  task automatic do_op(input vec_t v, input int id);
    int lat, ren_n, wen_n;
    logic [31:0] wd, wa, ra;
    bit got;
    lat = 0; ren_n = 0; wen_n = 0; wd = 0; wa = 0; ra = 0; got = 0;
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_sign = v.sign; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1; lat = k;
      end else begin
        if (mem_ren) begin ren_n++; ra = mem_raddr; end
        if (mem_wen) begin wen_n++; wd = mem_wdata; wa = mem_waddr; end
      end
    end
    chk($sformatf("v%0d resp_seen", id), 32'(got), 32'd1);
    chk($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d rdata", id), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err", id), 32'(resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d ren_cycles", id), 32'(ren_n), 32'(v.exp_ren));
    chk($sformatf("v%0d wen_cycles", id), 32'(wen_n), 32'(v.exp_wen));
    chk($sformatf("v%0d req_ready_busy", id), 32'(req_ready), 32'd0);
    if (v.exp_ren != 0) chk($sformatf("v%0d raddr", id), ra, v.exp_idx);
    if (v.exp_wen != 0) begin
      chk($sformatf("v%0d waddr", id), wa, v.exp_idx);
      chk($sformatf("v%0d wdata", id), wd, v.exp_wdata);
    end
    @(negedge clk);
    chk($sformatf("v%0d idle_ready", id), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d idle_valid", id), 32'(resp_valid), 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    int wen_before;
    vec_t v;
    bit seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    //           wen  addr    wdata        sz  sg exp_rdata    err lat ren wen exp_wdata    idx
    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 32'd4};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0,        32'd4};
    vecs[2]  = '{1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, 32'h0,        1'b0, 2, 0, 1, 32'h11223344, 32'd4};
    vecs[3]  = '{1'b1, 32'h12, 32'h123456AB, 2'd0, 1'b0, 32'h0,        1'b0, 3, 1, 1, 32'h11AB3344, 32'd4};
    vecs[4]  = '{1'b0, 32'h12, 32'h0,        2'd0, 1'b1, 32'hFFFFFFAB, 1'b0, 2, 1, 0, 32'h0,        32'd4};
    vecs[5]  = '{1'b0, 32'h12, 32'h0,        2'd0, 1'b0, 32'h000000AB, 1'b0, 2, 1, 0, 32'h0,        32'd4};
    vecs[6]  = '{1'b0, 32'h12, 32'h0,        2'd1, 1'b1, 32'h000011AB, 1'b0, 2, 1, 0, 32'h0,        32'd4};
    vecs[7]  = '{1'b1, 32'h16, 32'h0000BEEF, 2'd1, 1'b0, 32'h0,        1'b0, 3, 1, 1, 32'hBEEF0000, 32'd5};
    vecs[8]  = '{1'b0, 32'h16, 32'h0,        2'd1, 1'b1, 32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0,        32'd5};
    vecs[9]  = '{1'b0, 32'h17, 32'h0,        2'd0, 1'b0, 32'h000000BE, 1'b0, 2, 1, 0, 32'h0,        32'd5};
    vecs[10] = '{1'b0, 32'h13, 32'h0,        2'd1, 1'b1, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'd0};
    vecs[11] = '{1'b1, 32'h402, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,       1'b1, 1, 0, 0, 32'h0,        32'd0};
    vecs[12] = '{1'b0, 32'h20, 32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'd0};
    vecs[13] = '{1'b0, 32'h400, 32'h0,       2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'd0};
    vecs[14] = '{1'b1, 32'h3FF, 32'h000000A5, 2'd0, 1'b0, 32'h0,       1'b0, 3, 1, 1, 32'hA5000000, 32'd255};
    vecs[15] = '{1'b0, 32'h3FC, 32'h0,       2'd2, 1'b0, 32'hA5000000, 1'b0, 2, 1, 0, 32'h0,        32'd255};

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_sign = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset mem_strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_raddr", mem_raddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_op(vecs[i], i);

    // Backpressure: response held for five cycles with resp_ready low.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_sign = 1'b0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    chk("bp resp_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp hold_valid", 32'(resp_valid), 32'd1);
      chk("bp hold_rdata", resp_rdata, 32'h11AB3344);
      chk("bp hold_err", 32'(resp_err), 32'd0);
      chk("bp req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp release_valid", 32'(resp_valid), 32'd0);
    chk("bp release_ready", 32'(req_ready), 32'd1);

    // Reset during the read phase of a byte store.
    wen_before = wen_total;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h12; req_wdata = 32'h000000CD;
    req_size = 2'd0; req_sign = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid in_rd_ren", 32'(mem_ren), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid ren_cleared", 32'(mem_ren), 32'd0);
    chk("rst_mid wen_cleared", 32'(mem_wen), 32'd0);
    chk("rst_mid raddr_cleared", mem_raddr, 32'd0);
    chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid no_write", 32'(wen_total - wen_before), 32'd0);
    v = '{1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h11AB3344, 1'b0, 2, 1, 0, 32'h0, 32'd4};
    do_op(v, 99);

    chk("ren_wen_exclusive", 32'(collisions), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
